// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared field layout, requester IDs and destination encoding for the forward path
package router_pkg;

  localparam int RP_DATA_WIDTH = 32;
  localparam int RP_DX_MSB     = 29;
  localparam int RP_DX_LSB     = 21;
  localparam int RP_DY_MSB     = 20;
  localparam int RP_DY_LSB     = 12;
  localparam int DX_W          = RP_DX_MSB - RP_DX_LSB + 1;

  // Requester IDs double as the round-robin pointer encoding.
  localparam logic REQ_LOC = 1'b0;
  localparam logic REQ_NBR = 1'b1;

  typedef enum logic [1:0] {
    DEST_A = 2'd0,
    DEST_B = 2'd1,
    DEST_C = 2'd2
  } dest_e;

endpackage

// File: rtl/path_input_fifo.sv
// rtl/path_input_fifo.sv - register-based input FIFO with a combinational head
module path_input_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // A push while full is dropped regardless of a same-cycle pop.
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage; contents are don't-care while the entry is unoccupied.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/forward_path_scheduler.sv
// rtl/forward_path_scheduler.sv - two-FIFO round-robin scheduler feeding the A/B/C forward paths
module forward_path_scheduler
  import router_pkg::*;
#(
  parameter int DATA_WIDTH   = RP_DATA_WIDTH,
  parameter int DX_MSB       = RP_DX_MSB,
  parameter int DX_LSB       = RP_DX_LSB,
  parameter int DY_MSB       = RP_DY_MSB,
  parameter int DY_LSB       = RP_DY_LSB,
  parameter int ADD          = -1,
  parameter int BUFFER_DEPTH = 4,
  localparam int DXW         = DX_MSB - DX_LSB + 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [DATA_WIDTH-1:0]     i_din_loc,
  input  logic                      i_wen_loc,
  output logic                      o_full_loc,
  input  logic [DATA_WIDTH-1:0]     i_din_nbr,
  input  logic                      i_wen_nbr,
  output logic                      o_full_nbr,
  input  logic                      i_full_a,
  input  logic                      i_full_b,
  input  logic                      i_full_c,
  output logic [DATA_WIDTH-1:0]     o_dout_a,
  output logic                      o_wen_a,
  output logic [DATA_WIDTH-DXW-1:0] o_dout_b,
  output logic                      o_wen_b,
  output logic [DATA_WIDTH-DXW-1:0] o_dout_c,
  output logic                      o_wen_c
);

  localparam logic [DXW-1:0] ADD_V = DXW'(ADD);

  logic [DATA_WIDTH-1:0]     w_head_loc, w_head_nbr, w_gnt_pkt, w_pkt_a;
  logic [DATA_WIDTH-DXW-1:0] w_pkt_bc;
  logic                      w_empty_loc, w_empty_nbr;
  logic                      w_elig_loc, w_elig_nbr, w_gnt_loc, w_gnt_nbr, w_gnt_any;
  dest_e                     w_dest_loc, w_dest_nbr, w_gnt_dest;
  logic                      r_rr;
  logic [DATA_WIDTH-1:0]     r_dout_a;
  logic [DATA_WIDTH-DXW-1:0] r_dout_b, r_dout_c;
  logic                      r_wen_a, r_wen_b, r_wen_c;

  // dx != 0 goes onward on A; otherwise the sign of dy picks north (B) or south (C).
  function automatic dest_e f_dest(input logic [DATA_WIDTH-1:0] p);
    if (p[DX_MSB:DX_LSB] != '0)             return DEST_A;
    else if ($signed(p[DY_MSB:DY_LSB]) >= 0) return DEST_B;
    else                                     return DEST_C;
  endfunction

  function automatic logic f_blocked(input dest_e d);
    case (d)
      DEST_A:  return i_full_a;
      DEST_B:  return i_full_b;
      DEST_C:  return i_full_c;
      default: return 1'b1;
    endcase
  endfunction

  path_input_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(BUFFER_DEPTH)) u_fifo_loc (
    .i_clk(i_clk), .i_rst(i_rst), .i_push(i_wen_loc), .i_pop(w_gnt_loc),
    .i_din(i_din_loc), .o_head(w_head_loc), .o_empty(w_empty_loc), .o_full(o_full_loc)
  );

  path_input_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(BUFFER_DEPTH)) u_fifo_nbr (
    .i_clk(i_clk), .i_rst(i_rst), .i_push(i_wen_nbr), .i_pop(w_gnt_nbr),
    .i_din(i_din_nbr), .o_head(w_head_nbr), .o_empty(w_empty_nbr), .o_full(o_full_nbr)
  );

  // Head-only eligibility and round-robin choice; the pointer side wins a tie.
  always_comb begin
    w_dest_loc = f_dest(w_head_loc);
    w_dest_nbr = f_dest(w_head_nbr);
    w_elig_loc = !w_empty_loc && !f_blocked(w_dest_loc);
    w_elig_nbr = !w_empty_nbr && !f_blocked(w_dest_nbr);
    w_gnt_loc  = w_elig_loc && ((r_rr == REQ_LOC) || !w_elig_nbr);
    w_gnt_nbr  = w_elig_nbr && !w_gnt_loc;
    w_gnt_any  = w_gnt_loc || w_gnt_nbr;
    w_gnt_pkt  = w_gnt_loc ? w_head_loc : w_head_nbr;
    w_gnt_dest = w_gnt_loc ? w_dest_loc : w_dest_nbr;
  end

  // Path A rewrites dx in place; B/C drop the dx field entirely.
  always_comb begin
    w_pkt_a                = w_gnt_pkt;
    w_pkt_a[DX_MSB:DX_LSB] = w_gnt_pkt[DX_MSB:DX_LSB] + ADD_V;
    w_pkt_bc               = {w_gnt_pkt[DATA_WIDTH-1:DX_MSB+1], w_gnt_pkt[DX_LSB-1:0]};
  end

  // Output registers and RR pointer; pointer only advances after serving its own side.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rr     <= REQ_LOC;
      r_wen_a  <= 1'b0;
      r_wen_b  <= 1'b0;
      r_wen_c  <= 1'b0;
      r_dout_a <= '0;
      r_dout_b <= '0;
      r_dout_c <= '0;
    end else begin
      if ((w_gnt_loc && r_rr == REQ_LOC) || (w_gnt_nbr && r_rr == REQ_NBR)) r_rr <= ~r_rr;
      r_wen_a <= w_gnt_any && (w_gnt_dest == DEST_A);
      r_wen_b <= w_gnt_any && (w_gnt_dest == DEST_B);
      r_wen_c <= w_gnt_any && (w_gnt_dest == DEST_C);
      if (w_gnt_any && w_gnt_dest == DEST_A) r_dout_a <= w_pkt_a;
      if (w_gnt_any && w_gnt_dest == DEST_B) r_dout_b <= w_pkt_bc;
      if (w_gnt_any && w_gnt_dest == DEST_C) r_dout_c <= w_pkt_bc;
    end
  end

  assign o_dout_a = r_dout_a;
  assign o_dout_b = r_dout_b;
  assign o_dout_c = r_dout_c;
  assign o_wen_a  = r_wen_a;
  assign o_wen_b  = r_wen_b;
  assign o_wen_c  = r_wen_c;

endmodule
